mux2to1_sel: RTL and testbench
==============================

// Module: mux2to1_sel
// PURPOSE
//  Parameterised 2:1 data selector for datapath steering. The combinational output follows the
//  selected input with zero latency. The block also provides a registered copy of the output and
//  a select-change pulse for downstream timing closure and monitoring.
//  Sits between producer stages and a single consumer; no handshake.
// PARAMETERS
//  WIDTH      1   data width of in0/in1/out/out_q
//  CNT_WIDTH  8   width of select-toggle counter (feature MUX2TO1_SWCNT_EN only)
// PORTS
//  clk        in   1          single clock; all flops rising-edge
//  rst_n      in   1          reset, asynchronous assert, active-low; deassert sync to clk externally
//  in0        in   WIDTH      data input, chosen when select=0
//  in1        in   WIDTH      data input, chosen when select=1
//  select     in   1          0 -> in0, 1 -> in1
//  out        out  WIDTH      combinational mux result
//  out_q      out  WIDTH      out registered by one clk
//  sel_chg    out  1          1-cycle pulse: select differs from its previous sampled value
//  sw_cnt     out  CNT_WIDTH  select-toggle count (feature only)
// BEHAVIOUR
//  - out = select ? in1 : in0; purely combinational, no clk dependence, valid during reset.
//  - X/Z on select: out is not specified beyond simulator semantics; no special handling.
//  - out_q <= out each rising clk; reset value all-zeros; latency exactly 1 cycle.
//  - sel_q <= select each clk (reset 0).
//  - sel_chg <= (select != sel_q), registered; reset 0.
//  - First select=1 after reset produces a sel_chg pulse (sel_q resets to 0).
//  - Input changes while select is static: out updates immediately; sel_chg stays 0.
//  - Simultaneous change of select and selected input: out reflects the new select and new data.
//  - rst_n asserted mid-operation: out_q, sel_q, sel_chg and sw_cnt clear immediately
//    (asynchronous); out keeps tracking its inputs.
// CONFIGURATION
//  Macro MUX2TO1_SWCNT_EN:
//   defined: sw_cnt increments by 1 on each cycle where sel_chg is set; saturates at
//            2**CNT_WIDTH-1 with no wrap; reset 0.
//   undefined: sw_cnt is tied to 0 and no counter flops are built; port kept for a stable interface.
// STRUCTURE
//  - Package mux2to1_pkg: default WIDTH/CNT_WIDTH localparams and the SEL_IN0=1'b0 / SEL_IN1=1'b1
//    constants.
//  - One sub-module, sat_counter (CNT_WIDTH, inc, clk, rst_n, cnt), instantiated under the macro.
//  - Everything else is a flat combinational assign plus one always_ff block with async reset.
//  - Instantiate by named ports.
// TESTING
//  1. WIDTH=1: in0=1, in1=0, sel=0 -> out=1; t+5ns sel=1 -> out=0; in1=1 -> out=1;
//     in1=0 -> out=0; in0=0 -> out=0; sel=0 -> out=0.
//  2. Hold rst_n=0, toggle inputs -> out tracks the mux; out_q=0, sel_chg=0, sw_cnt=0.
//  3. After reset, in0=8'hA5, sel=0, one clk -> out_q=8'hA5; sel=1 with in1=8'h3C ->
//     out=8'h3C immediately, out_q=8'h3C one clk later.
//  4. Toggle sel on 3 consecutive cycles -> 3 sel_chg pulses; with the macro, sw_cnt=3.
//  5. With the macro and CNT_WIDTH=2, toggle sel 6 times -> sw_cnt saturates at 3.
//  6. Assert rst_n mid-run between clk edges -> out_q, sel_chg and sw_cnt read 0 before the
//     next edge.

Source files
------------

// File: rtl/mux2to1_pkg.sv
// Shared defaults and select encodings for the 2:1 data selector.
package mux2to1_pkg;

    localparam int DEF_WIDTH     = 1;
    localparam int DEF_CNT_WIDTH = 8;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

endpackage : mux2to1_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter: adds one per cycle with inc set, holds at all-ones.
// Latency: count reflects inc one clk later. No backpressure; inc is sampled every cycle.
// Backpressure: none.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign cnt = r_cnt;

endmodule : sat_counter

// File: rtl/mux2to1_sel.sv
// 2:1 data selector with registered copy and select-change pulse; MUX2TO1_SWCNT_EN adds a toggle counter.
// Latency: out is combinational, out_q / sel_chg one clk; sw_cnt trails sel_chg by one clk.
// Backpressure: none; no handshake, every cycle is consumed.
module mux2to1_sel
    import mux2to1_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic                 select,
    output logic [WIDTH-1:0]     out,
    output logic [WIDTH-1:0]     out_q,
    output logic                 sel_chg,
    output logic [CNT_WIDTH-1:0] sw_cnt
);

    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] r_out_q;
    logic             r_sel_q;
    logic             r_sel_chg;

    // Pure combinational path: stays live through reset.
    assign w_out = (select == SEL_IN1) ? in1 : in0;
    assign out   = w_out;

    // r_sel_q resets to SEL_IN0 so the first select=1 after reset yields a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q   <= '0;
            r_sel_q   <= SEL_IN0;
            r_sel_chg <= 1'b0;
        end else begin
            r_out_q   <= w_out;
            r_sel_q   <= select;
            r_sel_chg <= (select != r_sel_q);
        end
    end

    assign out_q   = r_out_q;
    assign sel_chg = r_sel_chg;

`ifdef MUX2TO1_SWCNT_EN
    logic [CNT_WIDTH-1:0] w_sw_cnt;

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sw_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (r_sel_chg),
        .cnt   (w_sw_cnt)
    );

    assign sw_cnt = w_sw_cnt;
`else
    assign sw_cnt = '0;
`endif

endmodule : mux2to1_sel

// File: tb/tb_mux2to1_sel.sv
// Bench for mux2to1_sel: vector table, hand-written corner sequences, randomized run vs reference model.
module tb_mux2to1_sel;

    localparam int W    = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef MUX2TO1_SWCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in0, in1;
    logic          select;
    logic [W-1:0]  out, out_q;
    logic          sel_chg;
    logic [CW-1:0] sw_cnt;

    int errs   = 0;
    int checks = 0;

    // Reference model state
    logic [W-1:0] m_outq;
    bit           m_prev, m_chg;
    int           m_cnt;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] exp;
    } vec_t;
    vec_t tbl[6];

    mux2to1_sel #(.WIDTH(W), .CNT_WIDTH(CW)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in0     (in0),
        .in1     (in1),
        .select  (select),
        .out     (out),
        .out_q   (out_q),
        .sel_chg (sel_chg),
        .sw_cnt  (sw_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] ref_mux(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic [W-1:0] pick [2];
        pick[0] = a;
        pick[1] = b;
        return pick[s];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_outq = '0;
        m_prev = 1'b0;
        m_chg  = 1'b0;
        m_cnt  = 0;
    endtask

    // Advance one clock, update the model with what the edge saw, settle 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_chg && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_chg  = (select != m_prev);
            m_prev = select;
            m_outq = ref_mux(in0, in1, select);
        end
        #1;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_outq"},   32'(out_q),   32'(m_outq));
        chk({tag, "_selchg"}, 32'(sel_chg), 32'(m_chg));
        chk({tag, "_swcnt"},  32'(sw_cnt),  CNT_ON ? 32'(m_cnt) : 32'd0);
    endtask

    initial begin
        tbl[0] = '{a: 8'd1, b: 8'd0, s: 1'b0, exp: 8'd1};
        tbl[1] = '{a: 8'd1, b: 8'd0, s: 1'b1, exp: 8'd0};
        tbl[2] = '{a: 8'd1, b: 8'd1, s: 1'b1, exp: 8'd1};
        tbl[3] = '{a: 8'd1, b: 8'd0, s: 1'b1, exp: 8'd0};
        tbl[4] = '{a: 8'd0, b: 8'd0, s: 1'b1, exp: 8'd0};
        tbl[5] = '{a: 8'd0, b: 8'd0, s: 1'b0, exp: 8'd0};

        rst_n  = 1'b0;
        in0    = '0;
        in1    = '0;
        select = 1'b0;
        model_reset();
        #1;
        chk("reset_outq",   32'(out_q),   32'd0);
        chk("reset_selchg", 32'(sel_chg), 32'd0);
        chk("reset_swcnt",  32'(sw_cnt),  32'd0);

        // Held in reset: out tracks the mux, registers stay clear.
        for (int i = 0; i < 4; i++) begin
            in0    = W'($urandom);
            in1    = W'($urandom);
            select = i[0];
            #1;
            chk("inrst_out", 32'(out), 32'(ref_mux(in0, in1, select)));
            tick();
            chk("inrst_outq",   32'(out_q),   32'd0);
            chk("inrst_selchg", 32'(sel_chg), 32'd0);
            chk("inrst_swcnt",  32'(sw_cnt),  32'd0);
        end

        in0 = '0; in1 = '0; select = 1'b0;
        tick();
        rst_n = 1'b1;

        // Vector table: combinational result, then its registered copy.
        for (int i = 0; i < 6; i++) begin
            in0    = tbl[i].a;
            in1    = tbl[i].b;
            select = tbl[i].s;
            #1;
            chk("tbl_out", 32'(out), 32'(tbl[i].exp));
            tick();
            chk("tbl_outq", 32'(out_q), 32'(tbl[i].exp));
            chk_regs("tbl");
        end

        // Registered latency with wider data.
        in0 = 8'hA5; select = 1'b0;
        tick();
        chk("lat_outq_a5", 32'(out_q), 32'hA5);
        in1 = 8'h3C; select = 1'b1;
        #1;
        chk("lat_out_3c",     32'(out),   32'h3C);
        chk("lat_outq_hold",  32'(out_q), 32'hA5);
        tick();
        chk("lat_outq_3c",    32'(out_q),   32'h3C);
        chk("lat_selchg",     32'(sel_chg), 32'd1);
        chk_regs("lat");

        // Async reset between edges clears registers before the next edge.
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_outq",   32'(out_q),   32'd0);
        chk("arst_selchg", 32'(sel_chg), 32'd0);
        chk("arst_swcnt",  32'(sw_cnt),  32'd0);
        chk("arst_out",    32'(out),     32'h3C);
        select = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_selchg", 32'(sel_chg), 32'd0);

        // Three consecutive toggles, then a static cycle for the counter to catch up.
        for (int i = 0; i < 3; i++) begin
            select = ~select;
            tick();
            chk("tog3_selchg", 32'(sel_chg), 32'd1);
            chk_regs("tog3");
        end
        tick();
        chk("tog3_clear", 32'(sel_chg), 32'd0);
        chk("tog3_swcnt", 32'(sw_cnt),  CNT_ON ? 32'd3 : 32'd0);

        // Six more toggles: counter must hold at its ceiling.
        for (int i = 0; i < 6; i++) begin
            select = ~select;
            tick();
            chk_regs("sat");
        end
        tick();
        tick();
        chk("sat_swcnt", 32'(sw_cnt), CNT_ON ? 32'(CMAX) : 32'd0);

        // Randomized run with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            in0 = W'($urandom);
            in1 = W'($urandom);
            if ($urandom_range(0, 2) != 0) select = 1'($urandom);
            if (rst_n && $urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_regs("rnd_arst");
            end else if (!rst_n) begin
                rst_n = 1'b1;
            end
            #1;
            chk("rnd_out", 32'(out), 32'(ref_mux(in0, in1, select)));
            tick();
            chk_regs("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_mux2to1_sel
